// File: rtl/shift_reg_seq.sv
// rtl/shift_reg_seq.sv - load/shift pacing sequencer for the right-shift register stage
// Accepts one word, pulses sr_load, then issues SHIFTS sr_ena pulses spaced TICK_DIV clocks apart.
module shift_reg_seq #(
  parameter int DATA_W   = 4,
  parameter int SHIFTS   = 4,
  parameter int TICK_DIV = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ready,
  output logic                          sr_load,
  output logic                          sr_ena,
  output logic [DATA_W-1:0]             sr_data,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(SHIFTS+1)-1:0]   shift_cnt
);

  localparam int CNT_W  = $clog2(SHIFTS + 1);
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_PEN   = CNT_W'(SHIFTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                accept;

  assign in_ready = (state_q == ST_IDLE) & resetn & ~flush;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    if (flush) begin
      // Abort keeps the last word on sr_data so the shift stage input stays stable.
      state_d = ST_IDLE;
      tick_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            data_d  = in_data;
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          tick_d  = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_PEN) begin
              state_d = ST_DONE;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign sr_load   = (state_q == ST_LOAD);
  assign sr_ena    = (state_q == ST_SHIFT) && (tick_q == TICK_LAST);
  assign done      = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign sr_data   = data_q;
  assign shift_cnt = cnt_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// tb/tb_shift_reg_seq.sv - randomized bench for shift_reg_seq against a timeline model
// Two builds share inputs: TICK_DIV=3 and TICK_DIV=1.
module tb_shift_reg_seq;

  localparam int DATA_W = 4;
  localparam int SHIFTS = 4;
  localparam int CW     = $clog2(SHIFTS + 1);

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;

  logic              ir [2];
  logic              ld [2];
  logic              en [2];
  logic              dn [2];
  logic              bs [2];
  logic [DATA_W-1:0] sd [2];
  logic [CW-1:0]     sc [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Model: an accepted word is a timeline indexed by edges since the accept edge.
  int          td    [2] = '{3, 1};
  bit          m_act [2];
  int          m_p   [2];
  int          m_cnt [2];
  logic [3:0]  m_data[2];

  always #5 clk = ~clk;

  shift_reg_seq #(.DATA_W(DATA_W), .SHIFTS(SHIFTS), .TICK_DIV(3)) u_dut3 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir[0]), .sr_load(ld[0]), .sr_ena(en[0]), .sr_data(sd[0]),
    .busy(bs[0]), .done(dn[0]), .shift_cnt(sc[0])
  );

  shift_reg_seq #(.DATA_W(DATA_W), .SHIFTS(SHIFTS), .TICK_DIV(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir[1]), .sr_load(ld[1]), .sr_ena(en[1]), .sr_data(sd[1]),
    .busy(bs[1]), .done(dn[1]), .shift_cnt(sc[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input int i);
    int  p;
    int  last;
    int  e_cnt;
    bit  a;
    p    = m_p[i];
    a    = m_act[i];
    last = SHIFTS * td[i] + 1;
    if (!a || p == 0) e_cnt = m_cnt[i];
    else e_cnt = ((p - 1) / td[i] > SHIFTS) ? SHIFTS : (p - 1) / td[i];
    check($sformatf("u%0d_sr_load", i), 32'(ld[i]), 32'(a && p == 0));
    check($sformatf("u%0d_sr_ena", i), 32'(en[i]),
          32'(a && p >= td[i] && p <= SHIFTS * td[i] && (p % td[i]) == 0));
    check($sformatf("u%0d_done", i), 32'(dn[i]), 32'(a && p == last));
    check($sformatf("u%0d_busy", i), 32'(bs[i]), 32'(a));
    check($sformatf("u%0d_shift_cnt", i), 32'(sc[i]), 32'(e_cnt));
    check($sformatf("u%0d_sr_data", i), 32'(sd[i]), 32'(m_data[i]));
  endtask

  task automatic step(input logic rn, input logic fl, input logic v, input logic [3:0] d);
    bit rdy [2];
    @(negedge clk);
    resetn   = rn;
    flush    = fl;
    in_valid = v;
    in_data  = d;
    #1;
    for (int i = 0; i < 2; i++) begin
      rdy[i] = !m_act[i] && rn && !fl;
      check($sformatf("u%0d_in_ready", i), 32'(ir[i]), 32'(rdy[i]));
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rn) begin
        m_act[i] = 0; m_cnt[i] = 0; m_data[i] = '0;
      end else if (fl) begin
        m_act[i] = 0; m_cnt[i] = 0;
      end else if (m_act[i]) begin
        if (m_p[i] == SHIFTS * td[i] + 1) begin
          m_act[i] = 0; m_cnt[i] = SHIFTS;
        end else begin
          m_p[i]++;
        end
      end else if (v && rdy[i]) begin
        m_act[i] = 1; m_p[i] = 0; m_data[i] = d;
      end
    end
    #1;
    for (int i = 0; i < 2; i++) check_outs(i);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_p[i] = 0; m_cnt[i] = 0; m_data[i] = '0;
    end
    // Reset held with a word offered, then a single accept of B.
    step(1'b0, 1'b0, 1'b1, 4'hA);
    step(1'b0, 1'b0, 1'b1, 4'hA);
    step(1'b1, 1'b0, 1'b1, 4'hB);
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 1'b0, 4'h0);
    // Valid held while busy, data changing mid-run.
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b1, 4'hA);
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 1'b1, 4'h6);
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 1'b0, 4'h0);
    // Flush after the second pulse of the slow build.
    step(1'b1, 1'b0, 1'b1, 4'hB);
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b1, 1'b0, 4'h0);
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b0, 4'h0);
    // Reset mid-shift, then flush together with valid in IDLE.
    step(1'b1, 1'b0, 1'b1, 4'hF);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b1, 1'b1, 4'h9);
    step(1'b1, 1'b0, 1'b0, 4'h0);
    for (int k = 0; k < 3000; k++) begin
      step(logic'($urandom_range(0, 99) != 0),
           logic'($urandom_range(0, 59) == 0),
           logic'($urandom_range(0, 2) != 0),
           4'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
